// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding and default parameter values.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W     = 64;
    localparam int unsigned DEF_DATA_W     = 64;
    localparam int unsigned DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of back-to-back data grants taken while a fetch waits.
module arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one memory port, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_MAX data grants.
//
// state  | meaning
// IDLE   | no transaction; grant a requester and pulse mem_req this cycle
// BUSY_I | fetch outstanding; i_ack on mem_valid
// BUSY_D | data access outstanding; d_ack on mem_valid
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              i_stall,
    output logic              d_stall
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              fetch_first;
    logic              grant_i;
    logic              grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic at_max;

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (grant_d & i_req),
        .clr    (grant_i),
        .at_max (at_max)
    );

    assign fetch_first = at_max & i_req;
`else
    assign fetch_first = 1'b0;
`endif

    // Reset also gates the request-driven paths so every output reads 0 while held.
    assign grant_d = reset && (state_q == IDLE) && d_req && !fetch_first;
    assign grant_i = reset && (state_q == IDLE) && i_req && !grant_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = we_q;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_req   = 1'b1;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    mem_we    = d_we;
                end else if (grant_i) begin
                    mem_req   = 1'b1;
                    mem_addr  = i_addr;
                    mem_wdata = '0;
                    mem_we    = 1'b0;
                end
            end
            BUSY_I:  i_ack = mem_valid;
            BUSY_D:  d_ack = mem_valid;
            default: ;
        endcase
        i_rdata = i_ack ? mem_rdata[31:0] : i_rdata_q;
        d_rdata = d_ack ? mem_rdata : d_rdata_q;
    end

    assign i_stall = reset & i_req & ~i_ack;
    assign d_stall = reset & d_req & ~d_ack;

    always_comb begin
        addr_d    = mem_req ? mem_addr  : addr_q;
        wdata_d   = mem_req ? mem_wdata : wdata_q;
        we_d      = mem_req ? mem_we    : we_q;
        i_rdata_d = i_rdata;
        d_rdata_d = d_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of owner, captured command, returned data and starvation count.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_valid;
    logic [63:0] mem_rdata;
    logic        i_stall;
    logic        d_stall;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .i_stall   (i_stall),
        .d_stall   (d_stall)
    );

    int checks   = 0;
    int failures = 0;

    // model: 0 = nobody owns memory, 1 = fetch outstanding, 2 = data outstanding
    int          owner = 0;
    logic [63:0] c_addr = '0;
    logic [63:0] c_wdata = '0;
    logic        c_we = 1'b0;
    logic [31:0] e_ird = '0;
    logic [63:0] e_drd = '0;
    int          scnt = 0;
    logic        m_iack = 1'b0;
    logic        m_dack = 1'b0;

    // memory responder
    int          mem_cnt = -1;
    logic [63:0] mem_dat = '0;
    int          lat_force = 0;
    logic        dat_force_en = 1'b0;
    logic [63:0] dat_force = '0;
    logic        stray_en = 1'b0;

    // grant observations for the starvation scenario
    int obs_dg = 0;
    int obs_ig = 0;
    int first_ig_after = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample_check();
        logic gi, gd, ia, da, starve;
        #3;
        m_iack = 1'b0;
        m_dack = 1'b0;
        if (!reset) begin
            owner = 0;
            scnt  = 0;
            e_ird = '0;
            e_drd = '0;
            chk("rst_mem_req",   64'(mem_req),   64'd0);
            chk("rst_mem_addr",  mem_addr,       64'd0);
            chk("rst_mem_we",    64'(mem_we),    64'd0);
            chk("rst_mem_wdata", mem_wdata,      64'd0);
            chk("rst_i_ack",     64'(i_ack),     64'd0);
            chk("rst_d_ack",     64'(d_ack),     64'd0);
            chk("rst_i_rdata",   64'(i_rdata),   64'd0);
            chk("rst_d_rdata",   d_rdata,        64'd0);
            chk("rst_i_stall",   64'(i_stall),   64'd0);
            chk("rst_d_stall",   64'(d_stall),   64'd0);
        end else begin
            starve = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve = i_req && (scnt == STARVE_MAX);
`endif
            gd = (owner == 0) && d_req && !starve;
            gi = (owner == 0) && i_req && !gd;
            ia = (owner == 1) && mem_valid;
            da = (owner == 2) && mem_valid;
            chk("mem_req", 64'(mem_req), 64'(gd | gi));
            chk("i_ack",   64'(i_ack),   64'(ia));
            chk("d_ack",   64'(d_ack),   64'(da));
            chk("i_rdata", 64'(i_rdata), 64'(ia ? mem_rdata[31:0] : e_ird));
            chk("d_rdata", d_rdata,      ia ? e_drd : (da ? mem_rdata : e_drd));
            chk("i_stall", 64'(i_stall), 64'(i_req && !ia));
            chk("d_stall", 64'(d_stall), 64'(d_req && !da));
            if (gd) begin
                chk("mem_addr_d",  mem_addr,    d_addr);
                chk("mem_we_d",    64'(mem_we), 64'(d_we));
                chk("mem_wdata_d", mem_wdata,   d_wdata);
            end else if (gi) begin
                chk("mem_addr_i", mem_addr,    i_addr);
                chk("mem_we_i",   64'(mem_we), 64'd0);
            end else if (owner != 0) begin
                chk("hold_addr", mem_addr,    c_addr);
                chk("hold_we",   64'(mem_we), 64'(c_we));
                if (c_we) chk("hold_wdata", mem_wdata, c_wdata);
            end
            if (mem_req === 1'b1) begin
                if (mem_we === 1'b1) begin
                    obs_dg++;
                end else begin
                    obs_ig++;
                    if (first_ig_after < 0) first_ig_after = obs_dg;
                end
            end
            if (ia) begin
                e_ird = mem_rdata[31:0];
                owner = 0;
            end
            if (da) begin
                e_drd = mem_rdata;
                owner = 0;
            end
            if (gd || gi) begin
                owner   = gd ? 2 : 1;
                c_addr  = gd ? d_addr : i_addr;
                c_we    = gd ? d_we : 1'b0;
                c_wdata = d_wdata;
                if (gd && i_req && scnt < STARVE_MAX) scnt++;
                if (gi) scnt = 0;
                mem_cnt = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
                mem_dat = dat_force_en ? dat_force : {$urandom, $urandom};
            end
            m_iack = ia;
            m_dack = da;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_valid = 1'b1;
                mem_rdata = mem_dat;
                mem_cnt   = -1;
            end
        end else if (stray_en && owner == 0 && $urandom_range(0, 7) == 0) begin
            mem_valid = 1'b1;
            mem_rdata = {$urandom, $urandom};
        end
    endtask

    task automatic rand_drive();
        if (m_iack) i_req = 1'b0;
        if (m_dack) d_req = 1'b0;
        if (i_req && owner == 1 && $urandom_range(0, 15) == 0) i_req = 1'b0;
        if (!i_req && owner != 1 && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = {$urandom, $urandom};
        end
        if (!d_req && owner != 2 && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        @(posedge clk);
        #1;
        sample_check();
        advance();
        reset = 1'b1;
        sample_check();
        advance();

        // lone fetch, memory answers 2 cycles after the request
        lat_force    = 2;
        dat_force_en = 1'b1;
        dat_force    = 64'h0000_0000_00A0_0093;
        i_req  = 1'b1;
        i_addr = 64'h40;
        sample_check();
        chk("lone_mem_req_c0", 64'(mem_req), 64'd1);
        chk("lone_stall_c0",   64'(i_stall), 64'd1);
        advance();
        sample_check();
        chk("lone_stall_c1", 64'(i_stall), 64'd1);
        advance();
        sample_check();
        chk("lone_iack_c2",  64'(i_ack),   64'd1);
        chk("lone_rdata_c2", 64'(i_rdata), 64'h00A0_0093);
        advance();
        i_req = 1'b0;
        sample_check();
        chk("lone_rdata_hold", 64'(i_rdata), 64'h00A0_0093);
        advance();
        dat_force_en = 1'b0;

        // simultaneous fetch and store: store first, fetch one cycle after d_ack
        lat_force = 1;
        i_req   = 1'b1;
        i_addr  = 64'h80;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h100;
        d_wdata = 64'hDEAD;
        sample_check();
        chk("sim_data_we",   64'(mem_we), 64'd1);
        chk("sim_data_addr", mem_addr,    64'h100);
        advance();
        sample_check();
        chk("sim_dack",           64'(d_ack),   64'd1);
        chk("sim_no_req_at_ack",  64'(mem_req), 64'd0);
        advance();
        d_req = 1'b0;
        sample_check();
        chk("sim_fetch_req",  64'(mem_req), 64'd1);
        chk("sim_fetch_addr", mem_addr,     64'h80);
        advance();
        sample_check();
        advance();
        i_req = 1'b0;
        sample_check();
        advance();

        // both requesters held high continuously
        obs_dg         = 0;
        obs_ig         = 0;
        first_ig_after = -1;
        i_req   = 1'b1;
        i_addr  = 64'h200;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h300;
        d_wdata = 64'h55;
        for (int n = 0; n < 20; n++) begin
            sample_check();
            advance();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("starve_total_grants", 64'(obs_dg + obs_ig), 64'd10);
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_first_fetch_after", 64'(first_ig_after), 64'(STARVE_MAX));
        chk("starve_fetch_grants",      64'(obs_ig),         64'd2);
`else
        chk("starve_no_fetch", 64'(obs_ig), 64'd0);
`endif
        sample_check();
        advance();

        // reset while a load is outstanding; the late mem_valid must be ignored
        lat_force = 3;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h400;
        sample_check();
        advance();
        reset = 1'b0;
        d_req = 1'b0;
        sample_check();
        advance();
        reset = 1'b1;
        sample_check();
        advance();
        sample_check();
        chk("rst_late_valid_seen", 64'(mem_valid), 64'd1);
        chk("rst_no_dack",         64'(d_ack),     64'd0);
        chk("rst_drdata_zero",     d_rdata,        64'd0);
        advance();

        // stray mem_valid while idle
        mem_valid = 1'b1;
        mem_rdata = 64'h1234;
        sample_check();
        chk("stray_iack", 64'(i_ack),   64'd0);
        chk("stray_dack", 64'(d_ack),   64'd0);
        chk("stray_mreq", 64'(mem_req), 64'd0);
        advance();
        lat_force = 1;
        i_req  = 1'b1;
        i_addr = 64'h500;
        sample_check();
        chk("stray_then_grant", 64'(mem_req), 64'd1);
        advance();
        sample_check();
        advance();
        i_req = 1'b0;

        // fetch requester drops i_req while its transaction is outstanding
        lat_force = 3;
        i_req  = 1'b1;
        i_addr = 64'h600;
        sample_check();
        advance();
        i_req = 1'b0;
        sample_check();
        advance();
        sample_check();
        advance();
        sample_check();
        chk("drop_iack", 64'(i_ack), 64'd1);
        advance();
        sample_check();
        advance();

        // random traffic with occasional reset pulses and stray responses
        lat_force = 0;
        stray_en  = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 150) begin
                reset = 1'b0;
                i_req = 1'b0;
                d_req = 1'b0;
            end else begin
                reset = 1'b1;
                rand_drive();
            end
            sample_check();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
